// File: rtl/fp_lut_array_tile_scheduler_if.sv
// -----------------------------------------------------------------------------
// fp_lut_array_tile_scheduler_if
//
// Tile-descriptor handshake channel into the FP LUT array tile scheduler.
// A descriptor transfers on a cycle where tile_valid && tile_ready.
//
//   tile_valid    producer -> scheduler  descriptor valid
//   tile_ready    scheduler -> producer  descriptor accepted this cycle
//   tile_first_k  producer -> scheduler  first K slice (psum forced to zero)
//   tile_last_k   producer -> scheduler  last K slice (result captured)
//   tile_tag      producer -> scheduler  tag returned with the capture strobe
//
// Modports: master = descriptor producer, slave = scheduler.
// -----------------------------------------------------------------------------
interface fp_lut_array_tile_scheduler_if #(
  parameter int TAG_WIDTH = 4
);
  logic                 tile_valid;
  logic                 tile_ready;
  logic                 tile_first_k;
  logic                 tile_last_k;
  logic [TAG_WIDTH-1:0] tile_tag;

  modport master (
    output tile_valid,
    output tile_first_k,
    output tile_last_k,
    output tile_tag,
    input  tile_ready
  );

  modport slave (
    input  tile_valid,
    input  tile_first_k,
    input  tile_last_k,
    input  tile_tag,
    output tile_ready
  );
endinterface

// File: rtl/fp_lut_array_tile_scheduler.sv
// -----------------------------------------------------------------------------
// fp_lut_array_tile_scheduler
//
// Control-only sequencer for the bit-serial FP LUT array stage. Accepts tile
// descriptors, then walks the array through B_BIT bit-planes per tile with
// back-to-back issue. A last-K tile produces a one-cycle capture strobe with
// its tag PIPE_LAT cycles after its final plane. A credit counter keeps
// last-K tiles from overrunning the downstream result buffer.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   cfg_enable         permit new tile acceptance
//   tile               descriptor channel (slave modport)
//   arr_lut_load       load operand registers (accept cycle)
//   arr_plane_valid    array executing a plane
//   arr_b_index        current bit-plane
//   arr_psum_sel       adder takes external psum (plane 0)
//   arr_psum_zero      external psum forced to zero (first-K, plane 0)
//   cap_valid/cap_tag  capture strobe and tag of finished last-K tile
//   buf_release        downstream freed one result slot
//   credits            free result-buffer slots
//   busy               tile in flight or result still in the array pipeline
//   err_credit_ovf     sticky: release seen while all slots already free
//   perf_busy_cycles   saturating busy-cycle counter (optional)
//   perf_stall_cycles  saturating stall-cycle counter (optional)
//
// Optional feature macro: FP_LUT_SCHED_PERF_EN. When undefined, both perf
// outputs are tied to zero and no counter logic exists.
// -----------------------------------------------------------------------------
module fp_lut_array_tile_scheduler #(
  parameter int  B_BIT     = 2,
  parameter int  PIPE_LAT  = 2,
  parameter int  CREDITS   = 2,
  parameter int  TAG_WIDTH = 4,
  localparam int BW        = $clog2(B_BIT),
  localparam int CW        = $clog2(CREDITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_enable,
  fp_lut_array_tile_scheduler_if.slave tile,
  output logic                        arr_lut_load,
  output logic                        arr_plane_valid,
  output logic [BW-1:0]               arr_b_index,
  output logic                        arr_psum_sel,
  output logic                        arr_psum_zero,
  output logic                        cap_valid,
  output logic [TAG_WIDTH-1:0]        cap_tag,
  input  logic                        buf_release,
  output logic [CW-1:0]               credits,
  output logic                        busy,
  output logic                        err_credit_ovf,
  output logic [31:0]                 perf_busy_cycles,
  output logic [31:0]                 perf_stall_cycles
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [BW-1:0] LAST_IDX = BW'(B_BIT - 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  state_e               state, state_nx;
  logic [BW-1:0]        b_idx;
  logic                 first_k_q;
  logic                 last_k_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [CW-1:0]        credits_q;
  logic                 ovf_q;
  logic                 last_plane;
  logic                 tile_ready_c;
  logic                 accept;
  logic                 consume;

  // Valid/tag delay line from final plane to array result.
  logic [PIPE_LAT-1:0]  pipe_v;
  logic [TAG_WIDTH-1:0] pipe_tag [PIPE_LAT];

  assign last_plane = (state == RUN) && (b_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Next-state / handshake
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    tile_ready_c = 1'b0;
    accept       = 1'b0;
    // A last-K tile needs a free slot now; a release this same cycle only
    // shows up in credits_q next cycle, so it cannot enable acceptance.
    // Gated with rst_n so nothing is accepted while reset is held.
    tile_ready_c = rst_n && cfg_enable
                   && ((state == IDLE) || last_plane)
                   && (!tile.tile_last_k || (credits_q != '0));
    accept       = tile_ready_c && tile.tile_valid;
    unique case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_plane && !accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign tile.tile_ready = tile_ready_c;
  assign consume         = accept && tile.tile_last_k;

  // ---------------------------------------------------------------------------
  // State, plane counter and registered descriptor
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      b_idx     <= '0;
      first_k_q <= 1'b0;
      last_k_q  <= 1'b0;
      tag_q     <= '0;
    end else begin
      state <= state_nx;
      // Plane index restarts at 0 after the last plane whether the next cycle
      // is a back-to-back plane 0 or idle.
      b_idx <= ((state == RUN) && !last_plane) ? b_idx + BW'(1) : '0;
      if (accept) begin
        first_k_q <= tile.tile_first_k;
        last_k_q  <= tile.tile_last_k;
        tag_q     <= tile.tile_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture pipeline: a last-K final plane enters stage 0 at the following
  // edge and reaches the last stage PIPE_LAT cycles after that plane.
  // ---------------------------------------------------------------------------
  // NOTE: the tag array is reset as well so cap_tag reads zero after reset;
  // it is only PIPE_LAT small registers, not a RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v[0]   <= last_plane && last_k_q;
      pipe_tag[0] <= tag_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result-buffer credits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits_q <= CRED_MAX;
      ovf_q     <= 1'b0;
    end else begin
      // A release while every slot is already free is a downstream protocol
      // error; the count never exceeds CREDITS.
      if (buf_release && (credits_q == CRED_MAX)) ovf_q <= 1'b1;
      if (consume && !buf_release) begin
        credits_q <= credits_q - CW'(1);
      end else if (buf_release && !consume && (credits_q != CRED_MAX)) begin
        credits_q <= credits_q + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign arr_lut_load    = accept;
  assign arr_plane_valid = (state == RUN);
  assign arr_b_index     = b_idx;
  assign arr_psum_sel    = (state == RUN) && (b_idx == '0);
  assign arr_psum_zero   = arr_psum_sel && first_k_q;
  assign cap_valid       = pipe_v[PIPE_LAT-1];
  assign cap_tag         = pipe_tag[PIPE_LAT-1];
  assign credits         = credits_q;
  assign busy            = (state == RUN) || (|pipe_v);
  assign err_credit_ovf  = ovf_q;

`ifdef FP_LUT_SCHED_PERF_EN
  logic [31:0] busy_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (busy && (busy_cnt != '1)) busy_cnt <= busy_cnt + 32'd1;
      if (tile.tile_valid && !tile_ready_c && cfg_enable && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign perf_busy_cycles  = busy_cnt;
  assign perf_stall_cycles = stall_cnt;
`else
  assign perf_busy_cycles  = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fp_lut_array_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fp_lut_array_tile_scheduler
//
// Directed bench for fp_lut_array_tile_scheduler with default parameters
// (B_BIT=2, PIPE_LAT=2, CREDITS=2, TAG_WIDTH=4). Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge. Cycle
// numbers k0, k1, ... in comments count from the start of each scenario.
// -----------------------------------------------------------------------------
module tb_fp_lut_array_tile_scheduler;

  localparam int TAG_WIDTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable;
  logic        buf_release;
  logic        arr_lut_load;
  logic        arr_plane_valid;
  logic [0:0]  arr_b_index;
  logic        arr_psum_sel;
  logic        arr_psum_zero;
  logic        cap_valid;
  logic [3:0]  cap_tag;
  logic [1:0]  credits;
  logic        busy;
  logic        err_credit_ovf;
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_stall_cycles;

  int vec_cnt = 0;
  int err_cnt = 0;

  fp_lut_array_tile_scheduler_if #(.TAG_WIDTH(TAG_WIDTH)) tile_bus ();

  fp_lut_array_tile_scheduler #(
    .B_BIT(2), .PIPE_LAT(2), .CREDITS(2), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_enable       (cfg_enable),
    .tile             (tile_bus),
    .arr_lut_load     (arr_lut_load),
    .arr_plane_valid  (arr_plane_valid),
    .arr_b_index      (arr_b_index),
    .arr_psum_sel     (arr_psum_sel),
    .arr_psum_zero    (arr_psum_zero),
    .cap_valid        (cap_valid),
    .cap_tag          (cap_tag),
    .buf_release      (buf_release),
    .credits          (credits),
    .busy             (busy),
    .err_credit_ovf   (err_credit_ovf),
    .perf_busy_cycles (perf_busy_cycles),
    .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cfg_enable            = 1'b1;
    buf_release           = 1'b0;
    tile_bus.tile_valid   = 1'b0;
    tile_bus.tile_first_k = 1'b0;
    tile_bus.tile_last_k  = 1'b0;
    tile_bus.tile_tag     = '0;
  endtask

  // One reset edge; returns in the first cycle after reset.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    cfg_enable = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // ---------------- reset state ----------------
    mid();
    check("rst_credits",     32'(credits), 32'd2);
    check("rst_plane_valid", 32'(arr_plane_valid), 32'd0);
    check("rst_b_index",     32'(arr_b_index), 32'd0);
    check("rst_cap_valid",   32'(cap_valid), 32'd0);
    check("rst_cap_tag",     32'(cap_tag), 32'd0);
    check("rst_busy",        32'(busy), 32'd0);
    check("rst_err",         32'(err_credit_ovf), 32'd0);
    check("rst_ready_nocfg", 32'(tile_bus.tile_ready), 32'd0);
    check("rst_perf_busy",   perf_busy_cycles, 32'd0);
    check("rst_perf_stall",  perf_stall_cycles, 32'd0);
    tick();

    // ---------------- single first/last tile, tag 5 ----------------
    cfg_enable = 1'b1;
    tile_bus.tile_valid = 1'b1; tile_bus.tile_first_k = 1'b1;
    tile_bus.tile_last_k = 1'b1; tile_bus.tile_tag = 4'd5;
    mid();                                                   // k0: accept
    check("t1_ready", 32'(tile_bus.tile_ready), 32'd1);
    check("t1_load",  32'(arr_lut_load), 32'd1);
    check("t1_cred0", 32'(credits), 32'd2);
    tick();
    idle_inputs();
    mid();                                                   // k1: plane 0
    check("t1_pv0",   32'(arr_plane_valid), 32'd1);
    check("t1_bi0",   32'(arr_b_index), 32'd0);
    check("t1_sel0",  32'(arr_psum_sel), 32'd1);
    check("t1_zero0", 32'(arr_psum_zero), 32'd1);
    check("t1_cred1", 32'(credits), 32'd1);
    check("t1_load1", 32'(arr_lut_load), 32'd0);
    tick(); mid();                                           // k2: plane 1
    check("t1_pv1",   32'(arr_plane_valid), 32'd1);
    check("t1_bi1",   32'(arr_b_index), 32'd1);
    check("t1_sel1",  32'(arr_psum_sel), 32'd0);
    check("t1_zero1", 32'(arr_psum_zero), 32'd0);
    tick(); mid();                                           // k3: pipeline
    check("t1_pv_end", 32'(arr_plane_valid), 32'd0);
    check("t1_busy3",  32'(busy), 32'd1);
    check("t1_cap3",   32'(cap_valid), 32'd0);
    tick(); mid();                                           // k4: capture
    check("t1_cap4", 32'(cap_valid), 32'd1);
    check("t1_tag4", 32'(cap_tag), 32'd5);
    tick(); mid();                                           // k5
    check("t1_cap5",  32'(cap_valid), 32'd0);
    check("t1_busy5", 32'(busy), 32'd0);
    tick();

    // ---------------- three back-to-back non-last tiles ----------------
    do_reset();
    tile_bus.tile_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tile_bus.tile_first_k = (k == 0);
      tile_bus.tile_tag     = 4'(k);
      if (k == 5) tile_bus.tile_valid = 1'b0;
      mid();
      check($sformatf("b2b_load_k%0d", k), 32'(arr_lut_load),
            32'((k == 0) || (k == 2) || (k == 4)));
      check($sformatf("b2b_pv_k%0d", k), 32'(arr_plane_valid), 32'((k >= 1) && (k <= 6)));
      check($sformatf("b2b_bi_k%0d", k), 32'(arr_b_index),
            ((k >= 1) && (k <= 6)) ? 32'((k - 1) % 2) : 32'd0);
      check($sformatf("b2b_zero_k%0d", k), 32'(arr_psum_zero), 32'(k == 1));
      check($sformatf("b2b_cap_k%0d", k), 32'(cap_valid), 32'd0);
      tick();
    end
    check("b2b_credits", 32'(credits), 32'd2);

    // ---------------- credit exhaustion with four last-K tiles ----------------
    do_reset();
    tile_bus.tile_valid = 1'b1; tile_bus.tile_last_k = 1'b1; tile_bus.tile_tag = 4'd1;
    mid(); check("cr_k0_ready", 32'(tile_bus.tile_ready), 32'd1); tick();
    tile_bus.tile_tag = 4'd2;
    mid(); check("cr_k1_cred", 32'(credits), 32'd1);
           check("cr_k1_ready", 32'(tile_bus.tile_ready), 32'd0); tick();
    mid(); check("cr_k2_ready", 32'(tile_bus.tile_ready), 32'd1); tick();
    tile_bus.tile_tag = 4'd3;
    mid(); check("cr_k3_cred", 32'(credits), 32'd0); tick();
    mid(); check("cr_k4_ready", 32'(tile_bus.tile_ready), 32'd0);
           check("cr_k4_cap", 32'(cap_valid), 32'd1);
           check("cr_k4_tag", 32'(cap_tag), 32'd1); tick();
    mid(); check("cr_k5_ready", 32'(tile_bus.tile_ready), 32'd0);
           check("cr_k5_pv", 32'(arr_plane_valid), 32'd0); tick();
    buf_release = 1'b1;
    mid(); check("cr_k6_ready_rel", 32'(tile_bus.tile_ready), 32'd0);
           check("cr_k6_cap", 32'(cap_valid), 32'd1);
           check("cr_k6_tag", 32'(cap_tag), 32'd2); tick();
    buf_release = 1'b0;
    mid(); check("cr_k7_cred", 32'(credits), 32'd1);
           check("cr_k7_ready", 32'(tile_bus.tile_ready), 32'd1);
           check("cr_k7_load", 32'(arr_lut_load), 32'd1); tick();
    tile_bus.tile_tag = 4'd4;
    mid(); check("cr_k8_cred", 32'(credits), 32'd0); tick();
    mid(); check("cr_k9_ready", 32'(tile_bus.tile_ready), 32'd0);
           check("cr_k9_cred", 32'(credits), 32'd0); tick();
    tile_bus.tile_valid = 1'b0;
    mid(); check("cr_k10_cred", 32'(credits), 32'd0); tick();
    mid(); check("cr_k11_cap", 32'(cap_valid), 32'd1);
           check("cr_k11_tag", 32'(cap_tag), 32'd3); tick();

    // ---------------- credit overflow ----------------
    do_reset();
    buf_release = 1'b1;
    mid(); check("ovf_pre", 32'(err_credit_ovf), 32'd0); tick();
    buf_release = 1'b0;
    mid(); check("ovf_cred", 32'(credits), 32'd2);
           check("ovf_set", 32'(err_credit_ovf), 32'd1);
    tick(); tick(); tick();
    mid(); check("ovf_sticky", 32'(err_credit_ovf), 32'd1); tick();
    do_reset();
    mid(); check("ovf_cleared", 32'(err_credit_ovf), 32'd0); tick();

    // ---------------- reset during plane 1 of a last-K tile ----------------
    tile_bus.tile_valid = 1'b1; tile_bus.tile_last_k = 1'b1; tile_bus.tile_tag = 4'd9;
    mid(); check("mr_k0_load", 32'(arr_lut_load), 32'd1); tick();
    tile_bus.tile_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    mid(); check("mr_k2_bi", 32'(arr_b_index), 32'd1); tick();
    rst_n = 1'b1;
    mid(); check("mr_k3_busy", 32'(busy), 32'd0);
           check("mr_k3_cred", 32'(credits), 32'd2);
           check("mr_k3_pv", 32'(arr_plane_valid), 32'd0); tick();
    for (int k = 4; k < 7; k++) begin
      mid(); check($sformatf("mr_k%0d_cap", k), 32'(cap_valid), 32'd0); tick();
    end

    // ---------------- cfg_enable dropped mid-tile ----------------
    idle_inputs();
    tile_bus.tile_valid = 1'b1; tile_bus.tile_tag = 4'd7;
    mid(); check("cfg_k0_load", 32'(arr_lut_load), 32'd1); tick();
    cfg_enable = 1'b0;
    tick();
    mid(); check("cfg_k2_pv", 32'(arr_plane_valid), 32'd1);
           check("cfg_k2_bi", 32'(arr_b_index), 32'd1);
           check("cfg_k2_ready", 32'(tile_bus.tile_ready), 32'd0); tick();
    mid(); check("cfg_k3_pv", 32'(arr_plane_valid), 32'd0);
           check("cfg_k3_load", 32'(arr_lut_load), 32'd0); tick();

    // ---------------- performance counters ----------------
    do_reset();
    tile_bus.tile_valid = 1'b1; tile_bus.tile_last_k = 1'b1; tile_bus.tile_tag = 4'd1;
    tick();                                                  // k0 accept
    tile_bus.tile_tag = 4'd2;
    tick();                                                  // k1 stall
    tick();                                                  // k2 accept
    tile_bus.tile_valid = 1'b0;
    tick(); tick(); tick(); tick();                          // k3..k6
    mid();                                                   // k7
    check("pf_idle_busy", 32'(busy), 32'd0);
`ifdef FP_LUT_SCHED_PERF_EN
    check("pf_busy_base",  perf_busy_cycles, 32'd6);
    check("pf_stall_base", perf_stall_cycles, 32'd1);
`endif
    tile_bus.tile_valid = 1'b1; tile_bus.tile_tag = 4'd3;
    check("pf_k7_ready", 32'(tile_bus.tile_ready), 32'd0);
    tick(); tick();                                          // k8, k9
    buf_release = 1'b1;
    tick();                                                  // k10
    buf_release = 1'b0;
    mid(); check("pf_k10_ready", 32'(tile_bus.tile_ready), 32'd1); tick();
    tile_bus.tile_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();                  // k11..k15
    mid();                                                   // k16
    check("pf_end_busy", 32'(busy), 32'd0);
`ifdef FP_LUT_SCHED_PERF_EN
    check("pf_busy_total",  perf_busy_cycles, 32'd10);
    check("pf_stall_total", perf_stall_cycles, 32'd4);
`else
    check("pf_busy_off",  perf_busy_cycles, 32'd0);
    check("pf_stall_off", perf_stall_cycles, 32'd0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
